request_unit: RTL and testbench
===============================

Name: request_unit

Overview:
- Sequences memory requests between the decoded control word and the memory controller for the single-issue MIPS datapath. Sits directly downstream of the control unit, which supplies iREN/dREN/dWEN/halt.
- Arbitrates the instruction fetch and data access phases. Generates the PC advance enable.
- Keeps a sticky halt flag, a stall watchdog and a retired-instruction counter for the system bench.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive stall cycles, with no ihit in FETCH or no dhit in DATA, before timeout sets.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- cu_iREN  input  1  control unit instruction read enable.
- cu_dREN  input  1  control unit data read request for the current instruction.
- cu_dWEN  input  1  control unit data write request for the current instruction.
- cu_halt  input  1  current instruction is HALT.
- ihit  input  1  instruction memory access complete this cycle.
- dhit  input  1  data memory access complete this cycle.
- imemREN  output  1  instruction memory read request.
- dmemREN  output  1  data memory read request.
- dmemWEN  output  1  data memory write request.
- pc_en  output  1  single-cycle pulse: PC and register file may commit.
- halt  output  1  sticky halt indicator.
- timeout  output  1  sticky watchdog flag.
- instr_count  output  CNT_W  number of pc_en pulses since reset.

Behaviour:
- States: FETCH, DATA, HALTED. All state, counters and flags are registered on CLK; RST clears them asynchronously.
- Reset values:
  - State = FETCH.
  - dmemREN = dmemWEN = 0, pc_en = 0, halt = 0, timeout = 0, instr_count = 0.
  - imemREN = 0 while RST is high; it is 1 from the first cycle after RST deasserts.
- FETCH:
  - imemREN = cu_iREN; dmemREN = dmemWEN = 0.
  - ihit=0: stay; stall counter += 1.
  - ihit=1 and cu_halt=1: pc_en=0; next state = HALTED. Halt has priority over any data request.
  - ihit=1, cu_halt=0, cu_dREN=0, cu_dWEN=0: pc_en=1 combinationally this cycle; stay in FETCH.
  - ihit=1 with cu_dREN or cu_dWEN: pc_en=0; latch the request into dREN_q/dWEN_q; next state = DATA.
  - If cu_dREN and cu_dWEN are both 1, latch the write only (dWEN_q=1, dREN_q=0).
- DATA:
  - imemREN = 0; dmemREN = dREN_q; dmemWEN = dWEN_q. Outputs are held stable until dhit.
  - dhit=0: stay; stall counter += 1.
  - dhit=1: pc_en=1 this cycle; clear dREN_q/dWEN_q at the edge; next state = FETCH.
- HALTED: imemREN = dmemREN = dmemWEN = pc_en = 0; halt = 1. Exit only via RST.
- Cross-phase hits are ignored: ihit in DATA/HALTED and dhit in FETCH/HALTED have no effect.
- Stall counter:
  - Clears on every state change and on any accepted hit.
  - When it reaches TIMEOUT_CYCLES-1 while still stalling, timeout sets and stays set until RST.
  - The counter saturates; it never wraps.
- instr_count:
  - Increments on each pc_en pulse and wraps modulo 2^CNT_W.
  - The HALT instruction is not counted.
- Reset mid-operation (RST asserted in DATA with a request outstanding): dmemREN/dmemWEN drop asynchronously in that same cycle; there are no partial writes from this block.
- Latency: a non-memory instruction retires in the ihit cycle. A memory instruction retires in the dhit cycle, with a minimum of 1 cycle after its ihit.

Test Plan:
- Reset, then ihit=1 every cycle with no data requests for 5 cycles -> pc_en=1 on all 5 cycles, instr_count=5, imemREN=1 throughout, dmemREN=dmemWEN=0.
- LW: ihit with cu_dREN=1; dhit held 0 for 3 cycles, then 1 -> dmemREN=1 for 4 cycles, imemREN=0 during DATA, pc_en pulses only on the dhit cycle, then FETCH resumes.
- cu_dREN=cu_dWEN=1 with cu_halt=0 on ihit -> DATA phase shows dmemWEN=1, dmemREN=0. Repeat with cu_halt=1 -> HALTED, halt=1, instr_count unchanged, all requests 0; later ihit/dhit pulses ignored.
- TIMEOUT_CYCLES=8, ihit held 0 for 7 cycles, then 1 -> timeout stays 0. Next fetch: ihit held 0 for 8 cycles -> timeout=1 and remains 1 after ihit returns.
- SW in progress (dmemWEN=1, no dhit), assert RST for 1 cycle -> dmemWEN=0 in the same cycle. After release: state FETCH, instr_count=0, timeout=0, imemREN=1.
- CNT_W=4, retire 17 non-memory instructions -> instr_count=1. A stray dhit during FETCH -> no pc_en, no state change.

Source files
------------

// File: rtl/request_unit.sv
// Request sequencer between the decoded control word and the memory controller.
// Runs fetch/data phases, gates the PC, and keeps halt, watchdog and retire count.
module request_unit #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cu_iREN,
   input  logic             cu_dREN,
   input  logic             cu_dWEN,
   input  logic             cu_halt,
   input  logic             ihit,
   input  logic             dhit,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pc_en,
   output logic             halt,
   output logic             timeout,
   output logic [CNT_W-1:0] instr_count
);

   localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t             state;
   logic               dRenQ;
   logic               dWenQ;
   logic [STALL_W-1:0] stallCnt;

   logic inFetch;
   logic inData;
   logic fetchDone;
   logic fetchRetire;
   logic fetchMem;
   logic dataRetire;
   logic stalling;

   assign inFetch     = (state == FETCH);
   assign inData      = (state == DATA);
   assign fetchDone   = inFetch && ihit;
   assign fetchRetire = fetchDone && !cu_halt && !cu_dREN && !cu_dWEN;
   assign fetchMem    = fetchDone && !cu_halt && (cu_dREN || cu_dWEN);
   assign dataRetire  = inData && dhit;
   assign stalling    = (inFetch && !ihit) || (inData && !dhit);

   // RST gates the fetch request and commit pulse directly so neither leaks out during reset.
   assign imemREN = inFetch && cu_iREN && !RST;
   assign dmemREN = inData && dRenQ;
   assign dmemWEN = inData && dWenQ;
   assign pc_en   = (fetchRetire || dataRetire) && !RST;
   assign halt    = (state == HALTED);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= FETCH;
         dRenQ       <= 1'b0;
         dWenQ       <= 1'b0;
         stallCnt    <= '0;
         timeout     <= 1'b0;
         instr_count <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (fetchDone && cu_halt) begin
                  state <= HALTED;
               end else if (fetchMem) begin
                  // A combined read+write request is treated as a write.
                  state <= DATA;
                  dWenQ <= cu_dWEN;
                  dRenQ <= cu_dREN && !cu_dWEN;
               end
            end
            DATA: begin
               if (dhit) begin
                  state <= FETCH;
                  dRenQ <= 1'b0;
                  dWenQ <= 1'b0;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= FETCH;
            end
         endcase

         // Watchdog counter saturates at its trip point rather than wrapping.
         if (stalling) begin
            if (stallCnt == STALL_MAX) begin
               timeout <= 1'b1;
            end else begin
               stallCnt <= stallCnt + STALL_W'(1);
            end
         end else begin
            stallCnt <= '0;
         end

         if (pc_en) begin
            instr_count <= instr_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed scenarios plus randomized traffic
// compared against a phase-level reference model.
module tb_request_unit;

   localparam int TO = 8;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          cu_iREN = 1'b0;
   logic          cu_dREN = 1'b0;
   logic          cu_dWEN = 1'b0;
   logic          cu_halt = 1'b0;
   logic          ihit = 1'b0;
   logic          dhit = 1'b0;
   logic          imemREN;
   logic          dmemREN;
   logic          dmemWEN;
   logic          pc_en;
   logic          halt;
   logic          timeout;
   logic [CW-1:0] instr_count;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 = fetch, 1 = data, 2 = halted.
   int         mPhase;
   int         mRun;
   int         mCnt;
   bit         mRd;
   bit         mWr;
   bit         mTo;
   logic [9:0] expV;

   request_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST),
      .cu_iREN(cu_iREN), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
      .ihit(ihit), .dhit(dhit),
      .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .pc_en(pc_en), .halt(halt), .timeout(timeout), .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   function automatic logic [9:0] obsV();
      return {imemREN, dmemREN, dmemWEN, pc_en, halt, timeout, instr_count};
   endfunction

   task automatic modelReset();
      mPhase = 0; mRun = 0; mCnt = 0; mRd = 1'b0; mWr = 1'b0; mTo = 1'b0;
   endtask

   function automatic logic [9:0] modelExpect();
      logic im, dr, dw, pc, hl;
      im = 1'b0; dr = 1'b0; dw = 1'b0; pc = 1'b0;
      hl = (mPhase == 2);
      if (!RST) begin
         if (mPhase == 0) begin
            im = cu_iREN;
            pc = ihit && !cu_halt && !cu_dREN && !cu_dWEN;
         end else if (mPhase == 1) begin
            dr = mRd;
            dw = mWr;
            pc = dhit;
         end
      end
      return {im, dr, dw, pc, hl, mTo, CW'(mCnt)};
   endfunction

   task automatic modelCommit();
      bit stall, retire;
      if (RST) begin
         modelReset();
         return;
      end
      stall  = (mPhase == 0 && !ihit) || (mPhase == 1 && !dhit);
      retire = (mPhase == 0 && ihit && !cu_halt && !cu_dREN && !cu_dWEN) || (mPhase == 1 && dhit);
      if (stall) begin
         mRun++;
         if (mRun >= TO) mTo = 1'b1;
      end else begin
         mRun = 0;
      end
      if (retire) mCnt = (mCnt + 1) % (1 << CW);
      if (mPhase == 0 && ihit) begin
         if (cu_halt) mPhase = 2;
         else if (cu_dREN || cu_dWEN) begin
            mPhase = 1;
            mWr = cu_dWEN;
            mRd = cu_dREN && !cu_dWEN;
         end
      end else if (mPhase == 1 && dhit) begin
         mPhase = 0;
      end
   endtask

   // Apply inputs just after the falling edge, then let them settle before sampling.
   task automatic drive(input bit ir, input bit dr, input bit dw, input bit h, input bit ih, input bit dh);
      cu_iREN = ir; cu_dREN = dr; cu_dWEN = dw; cu_halt = h; ihit = ih; dhit = dh;
      #2;
      expV = modelExpect();
   endtask

   task automatic advance();
      @(posedge CLK);
      modelCommit();
      @(negedge CLK);
   endtask

   task automatic doReset();
      RST = 1'b1;
      modelReset();
      drive(1, 0, 0, 0, 0, 0);
      advance();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      modelReset();
      drive(1, 0, 0, 0, 1, 1);
      checks++;
      if (obsV() !== 10'b0) begin
         errors++; $display("FAIL reset_vals got %b exp %b", obsV(), 10'b0);
      end
      advance();
      RST = 1'b0;
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (imemREN !== 1'b1) begin
         errors++; $display("FAIL reset_release_imem got %b exp 1", imemREN);
      end
      checks++;
      if (obsV() !== expV) begin
         errors++; $display("FAIL reset_release got %b exp %b", obsV(), expV);
      end
      advance();
   endtask

   task automatic test_alu_stream();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 1, 0);
         checks++;
         if (obsV() !== expV) begin
            errors++; $display("FAIL alu[%0d] got %b exp %b", i, obsV(), expV);
         end
         checks++;
         if ({imemREN, dmemREN, dmemWEN, pc_en} !== 4'b1001) begin
            errors++; $display("FAIL alu_ports[%0d] got %b exp 1001", i, {imemREN, dmemREN, dmemWEN, pc_en});
         end
         advance();
      end
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (instr_count !== CW'(5)) begin
         errors++; $display("FAIL alu_count got %0d exp 5", instr_count);
      end
      advance();
   endtask

   task automatic test_load();
      int rdCycles, pcPulses;
      bit hitPat [4] = '{0, 0, 0, 1};
      rdCycles = 0; pcPulses = 0;
      drive(1, 1, 0, 0, 1, 0);
      checks++;
      if (pc_en !== 1'b0 || obsV() !== expV) begin
         errors++; $display("FAIL lw_fetch got %b exp %b", obsV(), expV);
      end
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), hitPat[i]);
         if (dmemREN === 1'b1 && imemREN === 1'b0) rdCycles++;
         if (pc_en === 1'b1) pcPulses++;
         checks++;
         if (obsV() !== expV) begin
            errors++; $display("FAIL lw_data[%0d] got %b exp %b", i, obsV(), expV);
         end
         advance();
      end
      checks++;
      if (rdCycles != 4 || pcPulses != 1) begin
         errors++; $display("FAIL lw_shape got rd=%0d pc=%0d exp rd=4 pc=1", rdCycles, pcPulses);
      end
      drive(1, 0, 0, 0, 1, 0);
      checks++;
      if (imemREN !== 1'b1 || pc_en !== 1'b1) begin
         errors++; $display("FAIL lw_resume got imem=%b pc=%b exp 1 1", imemREN, pc_en);
      end
      advance();
   endtask

   task automatic test_both_and_halt();
      drive(1, 1, 1, 0, 1, 0);
      advance();
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin
         errors++; $display("FAIL both_wr got wen=%b ren=%b exp 1 0", dmemWEN, dmemREN);
      end
      advance();
      drive(1, 0, 0, 0, 0, 1);
      advance();
      drive(1, 1, 1, 1, 1, 0);
      checks++;
      if (pc_en !== 1'b0 || obsV() !== expV) begin
         errors++; $display("FAIL halt_fetch got %b exp %b", obsV(), expV);
      end
      advance();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (halt !== 1'b1 || {imemREN, dmemREN, dmemWEN, pc_en} !== 4'b0000 || instr_count !== CW'(mCnt)) begin
            errors++; $display("FAIL halted[%0d] got %b exp halt=1 req=0 cnt=%0d", i, obsV(), mCnt);
         end
         advance();
      end
   endtask

   task automatic test_timeout();
      doReset();
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         advance();
      end
      drive(1, 0, 0, 0, 1, 0);
      checks++;
      if (timeout !== 1'b0) begin
         errors++; $display("FAIL timeout_7 got %b exp 0", timeout);
      end
      advance();
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         checks++;
         if (obsV() !== expV) begin
            errors++; $display("FAIL timeout_run[%0d] got %b exp %b", i, obsV(), expV);
         end
         advance();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 1, 0);
         checks++;
         if (timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_8[%0d] got %b exp 1", i, timeout);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_sw();
      drive(1, 0, 1, 0, 1, 0);
      advance();
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (dmemWEN !== 1'b1) begin
         errors++; $display("FAIL sw_active got %b exp 1", dmemWEN);
      end
      advance();
      RST = 1'b1;
      modelReset();
      #1;
      checks++;
      if (dmemWEN !== 1'b0 || dmemREN !== 1'b0) begin
         errors++; $display("FAIL sw_async_drop got wen=%b ren=%b exp 0 0", dmemWEN, dmemREN);
      end
      advance();
      RST = 1'b0;
      drive(1, 0, 0, 0, 1, 0);
      checks++;
      if (imemREN !== 1'b1 || instr_count !== '0 || timeout !== 1'b0 || pc_en !== 1'b1) begin
         errors++; $display("FAIL sw_after_reset got %b exp imem=1 cnt=0 to=0 pc=1", obsV());
      end
      advance();
   endtask

   task automatic test_wrap_and_stray();
      doReset();
      for (int i = 0; i < 17; i++) begin
         drive(1, 0, 0, 0, 1, 0);
         advance();
      end
      drive(1, 0, 0, 0, 0, 1);
      checks++;
      if (instr_count !== CW'(1)) begin
         errors++; $display("FAIL wrap_count got %0d exp 1", instr_count);
      end
      checks++;
      if (pc_en !== 1'b0) begin
         errors++; $display("FAIL stray_dhit_pc got %b exp 0", pc_en);
      end
      advance();
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if ({imemREN, dmemREN, dmemWEN, pc_en, instr_count} !== {4'b1000, CW'(1)}) begin
         errors++; $display("FAIL stray_dhit_state got %b exp %b", {imemREN, dmemREN, dmemWEN, pc_en, instr_count}, {4'b1000, CW'(1)});
      end
      advance();
   endtask

   task automatic test_random();
      doReset();
      for (int i = 0; i < 600; i++) begin
         if (($urandom_range(0, 63) == 0) || (mPhase == 2 && $urandom_range(0, 7) == 0)) begin
            RST = 1'b1;
            modelReset();
         end else begin
            RST = 1'b0;
         end
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
         checks++;
         if (obsV() !== expV) begin
            errors++; $display("FAIL random[%0d] got %b exp %b", i, obsV(), expV);
         end
         advance();
      end
      RST = 1'b0;
   endtask

   initial begin
      modelReset();
      @(negedge CLK);
      test_reset();
      test_alu_stream();
      test_load();
      test_both_and_halt();
      test_timeout();
      test_reset_mid_sw();
      test_wrap_and_stray();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
